// File: rtl/block_accumulator.sv
// block_accumulator
// Requests one block from the multiplier read port, sums and counts the
// returned words, and hands the result downstream with a valid/ack handshake.
// A stalled burst is aborted after TIMEOUT idle cycles and flagged.
// Optional build macro: BLOCK_ACC_MINMAX_EN adds unsigned max_out/min_out.
module block_accumulator #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    EN_accum,
    output logic                    RDY_accum,
    output logic                    EN_blockRead,
    input  logic                    VALID_memVal,
    input  logic [WIDTH-1:0]        memVal_data,
    output logic                    VALID_sum,
    input  logic                    ACK_sum,
    output logic [WIDTH+ADDR_W-1:0] sum_out,
    output logic [ADDR_W:0]         word_count,
    output logic                    err_timeout
`ifdef BLOCK_ACC_MINMAX_EN
    ,
    output logic [WIDTH-1:0]        max_out,
    output logic [WIDTH-1:0]        min_out
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_COLLECT,
        S_DONE
    } state_t;

    // Count value that, once one more word arrives, completes the block.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
    // Idle-counter value whose next increment reaches TIMEOUT.
    localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT - 1);

    state_t                  r_state;
    logic                    r_rdy;
    logic                    r_enRead;
    logic                    r_validSum;
    logic [WIDTH+ADDR_W-1:0] r_sum;
    logic [ADDR_W:0]         r_count;
    logic                    r_err;
    logic [15:0]             r_tcnt;
`ifdef BLOCK_ACC_MINMAX_EN
    logic [WIDTH-1:0]        r_max;
    logic [WIDTH-1:0]        r_min;
`endif

    logic [WIDTH+ADDR_W-1:0] w_dataExt;
    logic                    w_lastWord;
    logic                    w_timeoutHit;

    assign w_dataExt    = {{ADDR_W{1'b0}}, memVal_data};
    assign w_lastWord   = (r_count == LAST_CNT);
    assign w_timeoutHit = (r_tcnt == TO_LAST);

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rdy      <= 1'b0;
            r_enRead   <= 1'b0;
            r_validSum <= 1'b0;
            r_sum      <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_tcnt     <= '0;
`ifdef BLOCK_ACC_MINMAX_EN
            r_max      <= '0;
            r_min      <= '1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (EN_accum) begin
                        r_state  <= S_REQ;
                        r_rdy    <= 1'b0;
                        r_enRead <= 1'b1;
                        r_sum    <= '0;
                        r_count  <= '0;
                        r_err    <= 1'b0;
                        r_tcnt   <= '0;
`ifdef BLOCK_ACC_MINMAX_EN
                        r_max    <= '0;
                        r_min    <= '1;
`endif
                    end else begin
                        r_rdy <= 1'b1;
                    end
                end
                S_REQ: begin
                    r_enRead <= 1'b0;
                    r_state  <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (VALID_memVal) begin
                        r_sum   <= r_sum + w_dataExt;
                        r_count <= r_count + 1'b1;
                        r_tcnt  <= '0;
`ifdef BLOCK_ACC_MINMAX_EN
                        if (memVal_data > r_max) r_max <= memVal_data;
                        if (memVal_data < r_min) r_min <= memVal_data;
`endif
                        if (w_lastWord) begin
                            r_state    <= S_DONE;
                            r_validSum <= 1'b1;
                            r_err      <= 1'b0;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                        if (w_timeoutHit) begin
                            r_state    <= S_DONE;
                            r_validSum <= 1'b1;
                            r_err      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (ACK_sum) begin
                        r_state    <= S_IDLE;
                        r_validSum <= 1'b0;
                        r_rdy      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign RDY_accum    = r_rdy;
    assign EN_blockRead = r_enRead;
    assign VALID_sum    = r_validSum;
    assign sum_out      = r_sum;
    assign word_count   = r_count;
    assign err_timeout  = r_err;
`ifdef BLOCK_ACC_MINMAX_EN
    assign max_out      = r_max;
    assign min_out      = r_min;
`endif

endmodule

// File: tb/tb_block_accumulator.sv
// tb_block_accumulator
// Scoreboard bench: each block request pushes its expected result; a forked
// monitor pops and compares whenever VALID_sum rises, and checks that the
// result stays stable while it is held.
module tb_block_accumulator;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 6;

    typedef struct packed {
        logic [WIDTH+ADDR_W-1:0] sum;
        logic [ADDR_W:0]         count;
        logic                    err;
        logic [WIDTH-1:0]        maxv;
        logic [WIDTH-1:0]        minv;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    EN_accum;
    logic                    RDY_accum;
    logic                    EN_blockRead;
    logic                    VALID_memVal;
    logic [WIDTH-1:0]        memVal_data;
    logic                    VALID_sum;
    logic                    ACK_sum;
    logic [WIDTH+ADDR_W-1:0] sum_out;
    logic [ADDR_W:0]         word_count;
    logic                    err_timeout;
`ifdef BLOCK_ACC_MINMAX_EN
    logic [WIDTH-1:0]        max_out;
    logic [WIDTH-1:0]        min_out;
`endif

    int   nTests = 0;
    int   nFail  = 0;
    int   readPulses = 0;
    exp_t expQ[$];

    block_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .EN_accum     (EN_accum),
        .RDY_accum    (RDY_accum),
        .EN_blockRead (EN_blockRead),
        .VALID_memVal (VALID_memVal),
        .memVal_data  (memVal_data),
        .VALID_sum    (VALID_sum),
        .ACK_sum      (ACK_sum),
        .sum_out      (sum_out),
        .word_count   (word_count),
        .err_timeout  (err_timeout)
`ifdef BLOCK_ACC_MINMAX_EN
        ,
        .max_out      (max_out),
        .min_out      (min_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pops the scoreboard on each new result and checks hold stability.
    task automatic monitorLoop();
        logic prevValid = 1'b0;
        exp_t held;
        forever begin
            @(negedge clk);
            if (EN_blockRead) readPulses++;
            if (VALID_sum && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", 64'(VALID_sum), 64'd0);
                end else begin
                    held = expQ.pop_front();
                    checkOutput("sum_out", 64'(sum_out), 64'(held.sum));
                    checkOutput("word_count", 64'(word_count), 64'(held.count));
                    checkOutput("err_timeout", 64'(err_timeout), 64'(held.err));
`ifdef BLOCK_ACC_MINMAX_EN
                    checkOutput("max_out", 64'(max_out), 64'(held.maxv));
                    checkOutput("min_out", 64'(min_out), 64'(held.minv));
`endif
                end
            end else if (VALID_sum && prevValid) begin
                checkOutput("held_stable",
                            64'({sum_out == held.sum, word_count == held.count, err_timeout == held.err}),
                            64'd7);
            end
            prevValid = VALID_sum && !rst;
        end
    endtask

    // One block transaction: request, feed squares, wait for result, acknowledge.
    task automatic applyStimulus(input int nWords, input int gap, input int expLat,
                                 input int ackDelay, input bit stray, input exp_t e);
        int cnt;
        int pulsesAtDone;
        expQ.push_back(e);
        @(posedge clk); #1;
        EN_accum = 1'b1;
        @(posedge clk); #1;
        EN_accum = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < nWords; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = WIDTH'(i * i);
            @(posedge clk); #1;
            VALID_memVal = 1'b0;
            if (i != nWords - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
            end
        end
        cnt = 0;
        @(negedge clk);
        while (!VALID_sum && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("done_latency", 64'(cnt), 64'(expLat));
        pulsesAtDone = readPulses;
        for (int i = 0; i < ackDelay; i++) begin
            @(posedge clk); #1;
            EN_accum     = stray && (i == 5);
            VALID_memVal = stray && (i == 7);
            memVal_data  = 32'd12345;
        end
        EN_accum     = 1'b0;
        VALID_memVal = 1'b0;
        ACK_sum      = 1'b1;
        @(posedge clk); #1;
        ACK_sum = 1'b0;
        @(negedge clk);
        checkOutput("valid_after_ack", 64'(VALID_sum), 64'd0);
        checkOutput("rdy_after_ack", 64'(RDY_accum), 64'd1);
        if (stray) checkOutput("no_extra_blockread", 64'(readPulses), 64'(pulsesAtDone));
    endtask

    initial begin
        exp_t full;
        exp_t part;
        exp_t none;
        int   p0;
        full = '{sum: 38'd85344, count: 7'd64, err: 1'b0, maxv: 32'd3969, minv: 32'd0};
        part = '{sum: 38'd285, count: 7'd10, err: 1'b1, maxv: 32'd81, minv: 32'd0};
        none = '{sum: 38'd0, count: 7'd0, err: 1'b1, maxv: 32'd0, minv: 32'hFFFF_FFFF};

        rst = 1'b1; EN_accum = 1'b0; VALID_memVal = 1'b0; memVal_data = '0; ACK_sum = 1'b0;
        fork
            monitorLoop();
        join_none
        #2;
        checkOutput("rst_rdy", 64'(RDY_accum), 64'd0);
        checkOutput("rst_enread", 64'(EN_blockRead), 64'd0);
        checkOutput("rst_valid", 64'(VALID_sum), 64'd0);
        checkOutput("rst_sum", 64'(sum_out), 64'd0);
        checkOutput("rst_count", 64'(word_count), 64'd0);
        checkOutput("rst_err", 64'(err_timeout), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_rdy", 64'(RDY_accum), 64'd1);

        $display("[TB] back-to-back squares");
        p0 = readPulses;
        applyStimulus(64, 0, 0, 3, 1'b0, full);
        checkOutput("one_blockread", 64'(readPulses - p0), 64'd1);

        $display("[TB] squares with gaps");
        applyStimulus(64, 1, 0, 0, 1'b0, full);

        $display("[TB] timeout after 10 words");
        applyStimulus(10, 0, 255, 1, 1'b0, part);

        $display("[TB] timeout with no words");
        applyStimulus(0, 0, 255, 0, 1'b0, none);

        $display("[TB] long hold with stray requests");
        applyStimulus(64, 0, 0, 20, 1'b1, full);

        $display("[TB] reset mid-collect");
        @(posedge clk); #1; EN_accum = 1'b1;
        @(posedge clk); #1; EN_accum = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 30; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = WIDTH'(i * i);
            @(posedge clk); #1;
        end
        VALID_memVal = 1'b0;
        checkOutput("midrun_count", 64'(word_count), 64'd30);
        #1; rst = 1'b1; #1;
        checkOutput("arst_sum", 64'(sum_out), 64'd0);
        checkOutput("arst_count", 64'(word_count), 64'd0);
        checkOutput("arst_rdy", 64'(RDY_accum), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checkOutput("arst_idle_rdy", 64'(RDY_accum), 64'd1);

        $display("[TB] reset during request");
        @(posedge clk); #1; EN_accum = 1'b1;
        @(posedge clk); #1; EN_accum = 1'b0;
        checkOutput("req_enread", 64'(EN_blockRead), 64'd1);
        rst = 1'b1; #1;
        checkOutput("req_arst_enread", 64'(EN_blockRead), 64'd0);
        @(negedge clk); rst = 1'b0;

        $display("[TB] fresh full run");
        applyStimulus(64, 0, 0, 0, 1'b0, full);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/block_accumulator.md
Name: block_accumulator

Overview:
- Downstream consumer of the multiplier's block-read stream (EN_blockRead / VALID_memVal / memVal_data).
- On request, pulses EN_blockRead, collects DEPTH result words, accumulates their sum and counts them.
- Presents the result to the next stage with a valid/ack handshake.
- A timeout aborts a stalled burst and flags an error.

Parameters:
- WIDTH, 32, data word width; matches the multiplier memVal_data width.
- ADDR_W, 6, log2 of block size.
- DEPTH, 64, words per block; must equal 2**ADDR_W.
- TIMEOUT, 255, max consecutive cycles in COLLECT with no VALID_memVal before abort; valid range 1..65535.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- EN_accum  input  1  start request; sampled only in IDLE.
- RDY_accum  output  1  high in IDLE only.
- EN_blockRead  output  1  one-cycle pulse to the multiplier.
- VALID_memVal  input  1  word valid from the multiplier.
- memVal_data  input  WIDTH  word from the multiplier.
- VALID_sum  output  1  result valid; high in DONE.
- ACK_sum  input  1  result consumed.
- sum_out  output  WIDTH+ADDR_W  block sum.
- word_count  output  ADDR_W+1  words accepted.
- err_timeout  output  1  block aborted by timeout.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered (Moore).
- Reset values: state=IDLE, RDY_accum=0 during reset then 1, EN_blockRead=0, VALID_sum=0, sum_out=0, word_count=0, err_timeout=0, timeout counter=0.
- IDLE: RDY_accum=1. EN_accum=1 at an edge -> REQ.
- REQ: lasts exactly one cycle.
  - EN_blockRead=1 for that cycle.
  - sum_out, word_count, err_timeout and timeout counter cleared at entry.
  - Next edge -> COLLECT.
- COLLECT:
  - Each edge with VALID_memVal=1: sum_out += zero-extended memVal_data; word_count += 1; timeout counter cleared.
  - Edge accepting word DEPTH -> DONE with err_timeout=0.
  - Edges with VALID_memVal=0: timeout counter += 1. Counter reaching TIMEOUT -> DONE with err_timeout=1; word_count and sum_out hold the partial values.
- DONE:
  - VALID_sum=1; sum_out, word_count and err_timeout held stable.
  - ACK_sum=1 at an edge -> IDLE; VALID_sum drops next cycle.
  - ACK_sum is ignored outside DONE.
- Latency:
  - EN_accum edge k -> EN_blockRead high during cycle k+1.
  - Last word accepted at edge m -> VALID_sum high from m+1.
  - Minimum VALID_sum width is one cycle: ACK_sum may already be high at first visibility.
- Arithmetic:
  - Sum width WIDTH+ADDR_W; cannot overflow for DEPTH words.
  - word_count width ADDR_W+1, so DEPTH is representable.
- Boundary conditions:
  - EN_accum outside IDLE: ignored, no queuing.
  - VALID_memVal in IDLE, REQ or DONE: ignored; sum unchanged.
  - VALID_memVal beyond DEPTH words: not possible in COLLECT; any extras arrive in DONE and are ignored.
  - Simultaneous last-word and timeout in one cycle: impossible, since a valid word clears the counter; the valid word wins.
  - rst asserted mid-operation, any state: immediate return to reset values; EN_blockRead drops asynchronously.

Optional Feature:
- Macro: BLOCK_ACC_MINMAX_EN.
- Defined:
  - Adds outputs max_out and min_out, each WIDTH bits, unsigned.
  - Cleared at REQ: max_out=0, min_out=all ones.
  - Updated on every accepted word; held in DONE with the sum.
  - Reset values: max_out=0, min_out=all ones.
  - After a timeout with zero words accepted: min_out=all ones, max_out=0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Multiplier holds squares 0..63; EN_accum pulse; 64 back-to-back valids -> exactly one EN_blockRead pulse; sum_out=85344, word_count=64, err_timeout=0; VALID_sum held until ACK_sum.
- Same data with VALID_memVal every other cycle (gap 1 < TIMEOUT) -> sum_out=85344, word_count=64, err_timeout=0.
- Only 10 words (0..9 squared) then VALID_memVal stuck low -> after exactly 255 idle cycles DONE with err_timeout=1, word_count=10, sum_out=285.
- ACK_sum held low 20 cycles in DONE, EN_accum and stray VALID_memVal pulsed meanwhile -> outputs stable, no new EN_blockRead; ACK_sum -> IDLE, RDY_accum=1 next cycle.
- rst asserted mid-COLLECT after 30 words -> all outputs zero immediately, IDLE; fresh full run -> sum_out=85344.
- With BLOCK_ACC_MINMAX_EN, squares run -> min_out=0, max_out=3969; timeout with 0 words -> min_out=32'hFFFFFFFF, max_out=0.
